// File: rtl/fp_add_normalize.sv
// Add/normalize/round stage of the single-precision adder: three-stage pipeline
// with a global advance enable, RNE rounding and IEEE-754 packing.
module fp_add_normalize #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 26
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   sign_of_great,
  input  logic                   sign_of_small,
  input  logic [EXP_W-1:0]       exp,
  input  logic [MAN_W-1:0]       mantis_great,
  input  logic [MAN_W-1:0]       mantis_small,
  input  logic                   loss,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W-3:0] result,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   inexact,
  output logic                   zero
);

  localparam int SUM_W  = MAN_W + 1;
  localparam int FRAC_W = MAN_W - 3;
  localparam int LZ_W   = $clog2(MAN_W);
  localparam int RES_W  = 1 + EXP_W + FRAC_W;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W:0]   EXP_MAX  = {1'b0, EXP_ONES};

  // Leading zeros counted from the hidden-bit position downward.
  function automatic logic [LZ_W-1:0] lzc(input logic [MAN_W-1:0] v);
    lzc = '0;
    for (int i = 0; i < MAN_W; i++)
      if (v[i]) lzc = LZ_W'(MAN_W - 1 - i);
  endfunction

  // Round-to-nearest-even on the fraction; the top bit is the carry into the exponent.
  function automatic logic [FRAC_W:0] round_rne(input logic [FRAC_W-1:0] frac,
                                                input logic grd, input logic stk);
    round_rne = {1'b0, frac} + (FRAC_W+1)'(grd & (stk | frac[0]));
  endfunction

  logic en;
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  // ---- S1: add / subtract magnitudes ----
  logic                    vld_p1_q;
  logic signed [SUM_W-1:0] sum_p1_d, sum_p1_q;
  logic [EXP_W-1:0]        exp_p1_q;
  logic                    sign_p1_q, spec_p1_q;
  logic [FRAC_W-1:0]       sfrac_p1_q;

  always_comb begin
    logic [SUM_W-1:0] a, b;
    a = {mantis_great, 1'b0};
    b = {mantis_small, loss};
    sum_p1_d = (sign_of_great ^ sign_of_small) ? signed'(a - b) : signed'(a + b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  vld_p1_q <= 1'b0;
    else if (en) vld_p1_q <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      sum_p1_q   <= sum_p1_d;
      exp_p1_q   <= exp;
      sign_p1_q  <= sign_of_great;
      spec_p1_q  <= (exp == EXP_ONES);
      sfrac_p1_q <= mantis_great[FRAC_W:1];
    end
  end

  // ---- S2: normalize ----
  logic              vld_p2_q;
  logic              sign_p2_d, zero_p2_d, uf_p2_d, grd_p2_d, stk_p2_d;
  logic [EXP_W:0]    exp_p2_d;
  logic [FRAC_W-1:0] frac_p2_d;
  logic              sign_p2_q, zero_p2_q, uf_p2_q, grd_p2_q, stk_p2_q, spec_p2_q;
  logic [EXP_W:0]    exp_p2_q;
  logic [FRAC_W-1:0] frac_p2_q;

  always_comb begin
    logic [MAN_W-2:0] nlow;
    logic [LZ_W-1:0]  lz;
    logic             stk_x;
    nlow      = '0;
    lz        = '0;
    stk_x     = 1'b0;
    sign_p2_d = sign_p1_q;
    zero_p2_d = 1'b0;
    uf_p2_d   = 1'b0;
    exp_p2_d  = {1'b0, exp_p1_q};
    if (spec_p1_q) begin
      nlow = {sfrac_p1_q, 2'b00};
    end else if (sum_p1_q == '0) begin
      sign_p2_d = 1'b0;
      zero_p2_d = 1'b1;
      exp_p2_d  = '0;
    end else if (sum_p1_q[SUM_W-1]) begin
      nlow     = sum_p1_q[MAN_W-1:1];
      stk_x    = sum_p1_q[0];
      exp_p2_d = {1'b0, exp_p1_q} + 1'b1;
    end else begin
      lz = lzc(sum_p1_q[MAN_W-1:0]);
      if ({1'b0, exp_p1_q} <= (EXP_W+1)'(lz)) begin
        zero_p2_d = 1'b1;
        uf_p2_d   = 1'b1;
        exp_p2_d  = '0;
      end else begin
        nlow     = (MAN_W-1)'(sum_p1_q << lz);
        exp_p2_d = {1'b0, exp_p1_q} - (EXP_W+1)'(lz);
      end
    end
    frac_p2_d = nlow[MAN_W-2:2];
    grd_p2_d  = nlow[1];
    stk_p2_d  = nlow[0] | stk_x;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  vld_p2_q <= 1'b0;
    else if (en) vld_p2_q <= vld_p1_q;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      sign_p2_q <= sign_p2_d;
      zero_p2_q <= zero_p2_d;
      uf_p2_q   <= uf_p2_d;
      spec_p2_q <= spec_p1_q;
      exp_p2_q  <= exp_p2_d;
      frac_p2_q <= frac_p2_d;
      grd_p2_q  <= grd_p2_d;
      stk_p2_q  <= stk_p2_d;
    end
  end

  // ---- S3: round and pack ----
  logic [RES_W-1:0] res_p3_d, res_p3_q;
  logic             ovf_p3_d, uf_p3_d, inx_p3_d, zero_p3_d;
  logic             vld_p3_q, ovf_p3_q, uf_p3_q, inx_p3_q, zero_p3_q;

  always_comb begin
    logic [FRAC_W:0] rnd;
    logic [EXP_W:0]  exp_r;
    rnd       = round_rne(frac_p2_q, grd_p2_q, stk_p2_q);
    exp_r     = exp_p2_q + (EXP_W+1)'(rnd[FRAC_W]);
    res_p3_d  = '0;
    ovf_p3_d  = 1'b0;
    uf_p3_d   = 1'b0;
    inx_p3_d  = 1'b0;
    zero_p3_d = 1'b0;
    if (!vld_p2_q) begin
      res_p3_d = '0;
    end else if (spec_p2_q) begin
      res_p3_d = {sign_p2_q, EXP_ONES, frac_p2_q};
    end else if (zero_p2_q) begin
      res_p3_d  = {sign_p2_q, {(EXP_W+FRAC_W){1'b0}}};
      zero_p3_d = 1'b1;
      uf_p3_d   = uf_p2_q;
    end else if (exp_r >= EXP_MAX) begin
      res_p3_d = {sign_p2_q, EXP_ONES, {FRAC_W{1'b0}}};
      ovf_p3_d = 1'b1;
      inx_p3_d = 1'b1;
    end else begin
      res_p3_d = {sign_p2_q, exp_r[EXP_W-1:0], rnd[FRAC_W-1:0]};
      inx_p3_d = grd_p2_q | stk_p2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p3_q  <= 1'b0;
      res_p3_q  <= '0;
      ovf_p3_q  <= 1'b0;
      uf_p3_q   <= 1'b0;
      inx_p3_q  <= 1'b0;
      zero_p3_q <= 1'b0;
    end else if (en) begin
      vld_p3_q  <= vld_p2_q;
      res_p3_q  <= res_p3_d;
      ovf_p3_q  <= ovf_p3_d;
      uf_p3_q   <= uf_p3_d;
      inx_p3_q  <= inx_p3_d;
      zero_p3_q <= zero_p3_d;
    end
  end

  assign out_valid = vld_p3_q;
  assign result    = res_p3_q;
  assign overflow  = ovf_p3_q;
  assign underflow = uf_p3_q;
  assign inexact   = inx_p3_q;
  assign zero      = zero_p3_q;

endmodule
